mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 16-bit instruction/data RAM.
- Requester 0 is the cpu memory port (mem_cmd / mem_addr / write data). Requester 1 is a secondary master, such as a program loader or DMA.
- Grants RAM ownership and multiplexes command, address and write data onto the RAM.
- Routes each synchronous-read result back to the requester that issued it, and bounds how long one owner may hold the RAM.

Parameters:
- AW, 9, address width.
- DW, 16, data width.
- MAX_HOLD, 8, maximum consecutive owned cycles while the other requester waits (range 2..255).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- req0_cmd  input  2  requester 0 command: 00 none, 01 write, 10 read, 11 treated as none.
- req0_addr  input  AW  requester 0 address.
- req0_wdata  input  DW  requester 0 write data.
- req0_lock  input  1  keep ownership across idle cycles.
- gnt0  output  1  requester 0 command accepted this cycle.
- rvalid0  output  1  rdata holds the requester 0 read result.
- req1_cmd, req1_addr, req1_wdata, req1_lock, gnt1, rvalid1: same as above, for requester 1.
- rdata  output  DW  read data, shared by both requesters (equals ram_rdata).
- ram_cmd  output  2  command to RAM (00/01/10).
- ram_addr  output  AW  address to RAM.
- ram_wdata  output  DW  write data to RAM.
- ram_rdata  input  DW  RAM read data; valid one cycle after a read is issued.
- owner  output  2  00 idle, 01 requester 0, 10 requester 1.
- busy  output  1  owner != idle.

Behaviour:
- Registered FSM with states IDLE, OWN0, OWN1. A requester is pending when its reqN_cmd is 01 or 10.
- Reset values: state IDLE, hold_cnt 0, last_owner 1, rd_pend 0, gnt0/gnt1 0, rvalid0/rvalid1 0, ram_cmd 00, owner 00, busy 0.
- Reset mid-operation: an in-flight read is dropped, so no rvalid follows reset.
- IDLE:
  - No grant is given. ram_cmd is 00.
  - Next state: OWN0 if only requester 0 is pending; OWN1 if only requester 1 is pending.
  - Both pending: the tie is resolved by the optional feature.
  - Arbitration latency is 1 cycle: the request must be held until gnt.
- OWNn:
  - gntN = pending(N), combinational.
  - ram_cmd, ram_addr and ram_wdata follow requester N combinationally.
  - The non-owner's gnt is 0, and its inputs are ignored.
- hold_cnt:
  - Cleared on entry to any OWN state.
  - Increments each owned cycle while the other requester is pending; saturates at MAX_HOLD.
- Release from OWNn. Evaluated each cycle, with priority (a) over (b):
  - (a) hold_cnt == MAX_HOLD-1 and the other requester is pending: forced release even if lock or pending is set. The current cycle's command still completes.
  - (b) Requester N is not pending and reqN_lock is 0.
  - On release: go to OWN(other) if the other is pending, otherwise IDLE. Handover is direct, with no idle bubble.
  - With lock held and no command: the state stays OWNn, ram_cmd is 00 and no grant is given.
- last_owner is updated on every transition into an OWN state.
- Read return:
  - A granted read sets rd_pend=1 and rd_id=N for one cycle.
  - In the next cycle, rvalidN=1 for rd_id only, with rdata=ram_rdata.
  - This holds even if ownership has changed meanwhile, so back-to-back reads across a handover return to the correct requester.
- Writes: the RAM captures on the grant cycle. There is no response.
- Both requesters change simultaneously: only the owner is sampled. A non-owner request asserted during the owner's release cycle takes effect in the next cycle (see the release rule).
- Widths: no arithmetic on address or data. hold_cnt is 8 bits.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a tie in IDLE, grant the requester that is not last_owner (round-robin).
- Not defined: fixed priority, where requester 0 always wins a tie in IDLE. last_owner is still maintained but unused.
- The forced-release rule (MAX_HOLD) applies in both builds.

Test Plan:
- Reset, then req0 read at addr 0x005 with RAM[5]=0x1234 → gnt0 in cycle 2; rvalid0=1 and rdata=0x1234 in cycle 3; owner=01.
- req1 write addr 0x010 data 0xBEEF while requester 0 is idle → gnt1 one cycle after request; RAM[0x10]=0xBEEF; rvalid1 never asserted.
- Both requesters issue reads from IDLE with last_owner=0:
  - With ARB_ROUND_ROBIN_EN → requester 1 granted first.
  - Without it → requester 0 granted first.
- req0 holds lock with continuous reads while req1 is pending, MAX_HOLD=4 → exactly 4 gnt0 cycles, then owner=10 directly; gnt1 follows with no bubble.
- req0 reads 0x001 on the final owned cycle before handover to requester 1 → rvalid0 (not rvalid1) in the next cycle, with RAM[1] data.
- Assert reset while a read is granted → the next cycle shows rvalid0=0, rvalid1=0, owner=00, ram_cmd=00.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester RAM arbiter with bounded hold and read-return routing; ARB_ROUND_ROBIN_EN selects round-robin tie-break
module mem_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req0_cmd,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req0_lock,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic [1:0]    req1_cmd,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic          req1_lock,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    ram_cmd,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [1:0]    owner,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
  state_t state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic last_owner_q, last_owner_d, rd_pend_q, rd_pend_d, rd_id_q, rd_id_d;
  logic p0, p1, own1, mine_p, other_p, mine_lock, rel, tie1;
  assign p0 = req0_cmd == 2'b01 || req0_cmd == 2'b10;
  assign p1 = req1_cmd == 2'b01 || req1_cmd == 2'b10;
  assign own1 = state_q == OWN1;
  assign busy = state_q != IDLE;
  assign owner = state_q;
  assign gnt0 = state_q == OWN0 && p0;
  assign gnt1 = own1 && p1;
  assign ram_cmd = (gnt0 || gnt1) ? (own1 ? req1_cmd : req0_cmd) : 2'b00;
  assign ram_addr = own1 ? req1_addr : req0_addr;
  assign ram_wdata = own1 ? req1_wdata : req0_wdata;
  assign rvalid0 = rd_pend_q && !rd_id_q;
  assign rvalid1 = rd_pend_q && rd_id_q;
  assign rdata = ram_rdata;
`ifdef ARB_ROUND_ROBIN_EN
  assign tie1 = !last_owner_q;
`else
  assign tie1 = 1'b0;
`endif
  // arbitration, forced/voluntary release, hold counting and read tagging
  always_comb begin
    mine_p = own1 ? p1 : p0;
    other_p = own1 ? p0 : p1;
    mine_lock = own1 ? req1_lock : req0_lock;
    rel = (hold_q == 8'(MAX_HOLD - 1) && other_p) || (!mine_p && !mine_lock);
    state_d = state_q == IDLE ? (p0 && p1 ? (tie1 ? OWN1 : OWN0) : p0 ? OWN0 : p1 ? OWN1 : IDLE)
            : rel ? (other_p ? (own1 ? OWN0 : OWN1) : IDLE) : state_q;
    hold_d = state_d != state_q ? 8'd0
           : (busy && other_p && hold_q != 8'(MAX_HOLD)) ? hold_q + 8'd1 : hold_q;
    last_owner_d = state_d == OWN1 ? 1'b1 : state_d == OWN0 ? 1'b0 : last_owner_q;
    rd_pend_d = ram_cmd == 2'b10;
    rd_id_d = own1;
  end
  // state registers; reset drops any in-flight read
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q <= 8'd0;
      last_owner_q <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      last_owner_q <= last_owner_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q <= rd_id_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with MAX_HOLD=4
module tb_mem_arbiter;
  logic clk, reset;
  logic [1:0] req0_cmd, req1_cmd, ram_cmd, owner;
  logic [8:0] req0_addr, req1_addr, ram_addr;
  logic [15:0] req0_wdata, req1_wdata, rdata, ram_wdata, ram_rdata;
  logic req0_lock, req1_lock, gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [15:0] mem [0:511];
  int n_cmp = 0;
  int n_fail = 0;
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [1:0] TIE_OWN = 2'b10;
  localparam logic [15:0] TIE_DATA = 16'h0C03;
`else
  localparam logic [1:0] TIE_OWN = 2'b01;
  localparam logic [15:0] TIE_DATA = 16'h0B02;
`endif

  mem_arbiter #(.AW(9), .DW(16), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .req0_cmd(req0_cmd), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_lock(req0_lock),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1_cmd(req1_cmd), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_lock(req1_lock),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .ram_cmd(ram_cmd), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      mem[1] <= 16'h0A01;
      mem[2] <= 16'h0B02;
      mem[3] <= 16'h0C03;
      mem[4] <= 16'h0D04;
      mem[5] <= 16'h1234;
    end else begin
      if (ram_cmd == 2'b01) mem[ram_addr] <= ram_wdata;
      if (ram_cmd == 2'b10) ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_cmd = 2'b00; req0_addr = '0; req0_wdata = '0; req0_lock = 1'b0;
    req1_cmd = 2'b00; req1_addr = '0; req1_wdata = '0; req1_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_owner", owner, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", {gnt0, gnt1}, 2'b00);
    chk("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
    chk("rst_ramcmd", ram_cmd, 2'b00);
    // requester 0 read of address 5
    step(); req0_cmd = 2'b10; req0_addr = 9'h005;
    @(negedge clk); chk("t1_idle_gnt0", gnt0, 1'b0); chk("t1_idle_ramcmd", ram_cmd, 2'b00);
    step(); @(negedge clk);
    chk("t1_gnt0", gnt0, 1'b1); chk("t1_owner", owner, 2'b01);
    chk("t1_ramcmd", ram_cmd, 2'b10); chk("t1_ramaddr", ram_addr, 9'h005);
    step(); req0_cmd = 2'b00; @(negedge clk);
    chk("t1_rvalid0", rvalid0, 1'b1); chk("t1_rvalid1", rvalid1, 1'b0);
    chk("t1_rdata", rdata, 16'h1234); chk("t1_owner_hold", owner, 2'b01);
    step(); @(negedge clk); chk("t1_back_idle", owner, 2'b00); chk("t1_busy", busy, 1'b0);
    // requester 1 write
    step(); req1_cmd = 2'b01; req1_addr = 9'h010; req1_wdata = 16'hBEEF;
    @(negedge clk); chk("t2_idle_gnt1", gnt1, 1'b0);
    step(); @(negedge clk);
    chk("t2_gnt1", gnt1, 1'b1); chk("t2_owner", owner, 2'b10); chk("t2_ramcmd", ram_cmd, 2'b01);
    chk("t2_ramaddr", ram_addr, 9'h010); chk("t2_wdata", ram_wdata, 16'hBEEF);
    step(); req1_cmd = 2'b00; @(negedge clk);
    chk("t2_rvalid1", rvalid1, 1'b0); chk("t2_mem", mem[9'h010], 16'hBEEF);
    step(); @(negedge clk); chk("t2_idle", owner, 2'b00); chk("t2_rvalid1_late", rvalid1, 1'b0);
    // requester 0 write so last_owner becomes 0
    step(); req0_cmd = 2'b01; req0_addr = 9'h020; req0_wdata = 16'h5555;
    step(); @(negedge clk); chk("t3p_gnt0", gnt0, 1'b1);
    step(); req0_cmd = 2'b00; @(negedge clk); chk("t3p_mem", mem[9'h020], 16'h5555);
    // simultaneous reads from idle
    step(); req0_cmd = 2'b10; req0_addr = 9'h002; req1_cmd = 2'b10; req1_addr = 9'h003;
    @(negedge clk); chk("t3_idle", owner, 2'b00); chk("t3_idle_gnt", {gnt0, gnt1}, 2'b00);
    step(); @(negedge clk);
    chk("t3_tie_owner", owner, TIE_OWN); chk("t3_tie_gnt", {gnt1, gnt0}, TIE_OWN);
    step(); req0_cmd = 2'b00; req1_cmd = 2'b00; @(negedge clk);
    chk("t3_rvalid", {rvalid1, rvalid0}, TIE_OWN); chk("t3_rdata", rdata, TIE_DATA);
    step(); @(negedge clk); chk("t3_idle_end", owner, 2'b00);
    // locked requester 0 forced out after MAX_HOLD grants
    step(); req0_cmd = 2'b10; req0_addr = 9'h001; req0_lock = 1'b1;
    @(negedge clk); chk("t4_idle", owner, 2'b00);
    step(); req1_cmd = 2'b10; req1_addr = 9'h004;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t4_gnt0_%0d", i), gnt0, 1'b1);
      chk($sformatf("t4_gnt1_%0d", i), gnt1, 1'b0);
      chk($sformatf("t4_owner_%0d", i), owner, 2'b01);
      step();
    end
    @(negedge clk);
    chk("t4_handover_owner", owner, 2'b10); chk("t4_handover_gnt1", gnt1, 1'b1);
    chk("t4_handover_gnt0", gnt0, 1'b0); chk("t4_ramaddr", ram_addr, 9'h004);
    chk("t5_rvalid0", rvalid0, 1'b1); chk("t5_rvalid1", rvalid1, 1'b0); chk("t5_rdata", rdata, 16'h0A01);
    step(); req1_cmd = 2'b00; @(negedge clk);
    chk("t5_rvalid1b", rvalid1, 1'b1); chk("t5_rvalid0b", rvalid0, 1'b0);
    chk("t5_rdata1", rdata, 16'h0D04); chk("t5_gnt1_off", gnt1, 1'b0); chk("t5_owner", owner, 2'b10);
    // reset during a granted read
    step(); reset = 1'b1; @(negedge clk);
    chk("t6_owner", owner, 2'b01); chk("t6_gnt0", gnt0, 1'b1);
    step(); reset = 1'b0; req0_cmd = 2'b00; req0_lock = 1'b0; @(negedge clk);
    chk("t6_rvalid", {rvalid0, rvalid1}, 2'b00); chk("t6_owner_rst", owner, 2'b00);
    chk("t6_ramcmd", ram_cmd, 2'b00); chk("t6_busy", busy, 1'b0);
    // lock held with no command keeps ownership without grants
    step(); req0_cmd = 2'b10; req0_addr = 9'h003; req0_lock = 1'b1;
    step(); @(negedge clk); chk("t7_gnt0", gnt0, 1'b1);
    step(); req0_cmd = 2'b00; @(negedge clk);
    chk("t7_lock_gnt0", gnt0, 1'b0); chk("t7_lock_ramcmd", ram_cmd, 2'b00); chk("t7_lock_owner", owner, 2'b01);
    step(); @(negedge clk); chk("t7_lock_owner2", owner, 2'b01);
    step(); req0_lock = 1'b0; @(negedge clk); chk("t7_release_cycle", owner, 2'b01);
    step(); @(negedge clk); chk("t7_released", owner, 2'b00);
    // command 11 is not a request
    step(); req0_cmd = 2'b11; @(negedge clk); chk("t8_gnt0", gnt0, 1'b0);
    step(); @(negedge clk);
    chk("t8_owner", owner, 2'b00); chk("t8_gnt0b", gnt0, 1'b0); chk("t8_ramcmd", ram_cmd, 2'b00);
    req0_cmd = 2'b00;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
